// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the transmit/receive state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_drain_if.sv
// FIFO read port between the host-output FIFO (slave) and the UART drain (master).
interface uart_tx_drain_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] fifo_d;
  logic                      fifo_empty;
  logic                      fifo_rd_en;

  modport master (input fifo_d, input fifo_empty, output fifo_rd_en);
  modport slave  (output fifo_d, output fifo_empty, input fifo_rd_en);

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high, tick marks the last cycle of a bit.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign tick   = run && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that pops bytes from the host-output FIFO and shifts them out LSB first.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tx_en,
  uart_tx_drain_if.master         fifo_if,
  output logic                    txd,
  output logic                    busy
);

  localparam int unsigned BIT_CNT_W = $clog2(UART_DATA_BITS);

  uart_state_t               r_state;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [BIT_CNT_W-1:0]      r_bit_cnt;
  logic                      r_txd;
  logic                      r_busy;
  logic                      w_tick;
  logic                      w_run;
  logic                      w_pop;

  // Pop only from IDLE and never while reset is held, so a reset cannot swallow a byte.
  assign w_pop              = rst_n && (r_state == IDLE) && tx_en && !fifo_if.fifo_empty;
  assign fifo_if.fifo_rd_en = w_pop;
  assign w_run              = (r_state != IDLE);
  assign txd                = r_txd;
  assign busy               = r_busy;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift   <= fifo_if.fifo_d;
            r_bit_cnt <= '0;
            r_txd     <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_txd   <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= DATA;
          end
        end
        DATA: begin
          // r_bit_cnt names the data bit currently on the line.
          if (w_tick) begin
            if (r_bit_cnt == BIT_CNT_W'(UART_DATA_BITS - 1)) begin
              r_txd   <= 1'b1;
              r_state <= STOP;
            end else begin
              r_txd     <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: directed frame checks plus a randomized FIFO/decoder scoreboard.
module tb_uart_tx_drain;
  import uart_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = int'(UART_FRAME_BITS) * CPB;
  localparam int N_RAND    = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx_en = 1'b0;
  logic txd;
  logic busy;

  uart_tx_drain_if bus ();

  uart_tx_drain #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_en   (tx_en),
    .fifo_if (bus.master),
    .txd     (txd),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO with registered head/empty outputs; it is not cleared by the DUT reset.
  logic [7:0]  fq[$];
  logic [7:0]  f_d     = 8'h00;
  logic        f_empty = 1'b1;
  int unsigned cyc     = 0;
  int unsigned pops    = 0;
  int unsigned viol    = 0;

  assign bus.fifo_d     = f_d;
  assign bus.fifo_empty = f_empty;

  always @(posedge clk) begin
    cyc++;
    if (bus.fifo_rd_en) begin
      pops++;
      if (f_empty) viol++;
      if (fq.size() > 0) void'(fq.pop_front());
    end
    f_empty <= (fq.size() == 0);
    f_d     <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line level per cycle of a frame: start 0, data LSB first, stop 1, each held CPB cycles.
  function automatic logic [63:0] frame_bits(input logic [7:0] b);
    logic [63:0] v;
    logic        bitv;
    v = '0;
    for (int k = 0; k < int'(UART_FRAME_BITS); k++) begin
      if (k == 0)      bitv = 1'b0;
      else if (k == 9) bitv = 1'b1;
      else             bitv = b[k-1];
      for (int j = 0; j < CPB; j++) v[k*CPB + j] = bitv;
    end
    return v;
  endfunction

  task automatic wait_pop(input string tag, output int unsigned at);
    int n;
    n = 0;
    while (bus.fifo_rd_en !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.fifo_rd_en !== 1'b1) chk({tag, "_pop_timeout"}, 64'(0), 64'(1));
    at = cyc;
  endtask

  // Called at the negedge of the pop cycle; samples the whole frame plus the following cycle.
  task automatic capture_frame(input string tag, input logic [7:0] b, input int drop_at);
    logic [63:0] got;
    int          busy_n;
    int          extra;
    got    = '0;
    busy_n = 0;
    extra  = 0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk);
      if (i == drop_at) tx_en = 1'b0;
      got[i] = txd;
      if (busy) busy_n++;
      if (bus.fifo_rd_en) extra++;
    end
    chk({tag, "_txd_seq"}, got, frame_bits(b));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(FRAME_CYC));
    chk({tag, "_pops_in_frame"}, 64'(extra), 64'(0));
    @(negedge clk);
    chk({tag, "_busy_after"}, 64'(busy), 64'(0));
    chk({tag, "_txd_after"}, 64'(txd), 64'(1));
  endtask

  logic [7:0]  exp_q[$];
  int          decoded = 0;
  bit          wr_done = 1'b0;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p0, p1, base, bad;

    // Reset held with a byte waiting
    rst_n = 1'b0;
    tx_en = 1'b1;
    @(negedge clk);
    fq.push_back(8'h11);
    @(negedge clk);
    chk("rst_txd", 64'(txd), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'(0));
    fq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || !txd || bus.fifo_rd_en) bad++;
    end
    chk("idle_after_rst", 64'(bad), 64'(0));
    chk("rst_pops", 64'(pops), 64'(0));

    // Single byte
    base = pops;
    fq.push_back(8'hA5);
    wait_pop("a5", p0);
    chk("a5_fifo_d", 64'(bus.fifo_d), 64'(8'hA5));
    capture_frame("a5", 8'hA5, -1);
    chk("a5_pop_count", 64'(pops - base), 64'(1));

    // Back-to-back frames
    base = pops;
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    wait_pop("b2b0", p0);
    capture_frame("b2b0", 8'h00, -1);
    wait_pop("b2b1", p1);
    chk("b2b_gap", 64'(p1 - p0), 64'(FRAME_CYC + 1));
    capture_frame("b2b1", 8'hFF, -1);
    chk("b2b_pop_count", 64'(pops - base), 64'(2));
    chk("b2b_fifo_left", 64'(fq.size()), 64'(0));

    // tx_en gating
    tx_en = 1'b0;
    base  = pops;
    fq.push_back(8'h5A);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) bad++;
    end
    chk("en_low_no_pop", 64'(bad + (pops - base)), 64'(0));
    tx_en = 1'b1;
    #1;
    chk("en_rise_same_cycle", 64'(bus.fifo_rd_en), 64'(1));
    capture_frame("en5a", 8'h5A, -1);

    // tx_en dropped mid-frame
    fq.push_back(8'hC3);
    fq.push_back(8'h99);
    @(negedge clk);
    wait_pop("drop", p0);
    capture_frame("drop", 8'hC3, 12);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) bad++;
    end
    chk("drop_no_next_pop", 64'(bad), 64'(0));
    chk("drop_fifo_left", 64'(fq.size()), 64'(1));
    tx_en = 1'b1;
    #1;
    wait_pop("drop99", p0);
    capture_frame("drop99", 8'h99, -1);

    // Reset in the middle of a data bit
    base = pops;
    fq.push_back(8'h3C);
    fq.push_back(8'h7E);
    @(negedge clk);
    wait_pop("r3c", p0);
    chk("r3c_fifo_d", 64'(bus.fifo_d), 64'(8'h3C));
    repeat (10) @(negedge clk);
    chk("r3c_pre_rst_txd", 64'(txd), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("r3c_async_txd", 64'(txd), 64'(1));
    chk("r3c_async_busy", 64'(busy), 64'(0));
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) bad++;
    end
    chk("r3c_no_pop_in_rst", 64'(bad), 64'(0));
    rst_n = 1'b1;
    #1;
    wait_pop("r7e", p0);
    chk("r7e_fifo_d", 64'(bus.fifo_d), 64'(8'h7E));
    capture_frame("r7e", 8'h7E, -1);
    chk("r3c_pop_count", 64'(pops - base), 64'(2));

    // Randomized scoreboard: writer, tx_en toggler and a txd decoder running together
    base = pops;
    fork
      begin
        logic [7:0] b;
        for (int i = 0; i < N_RAND; i++) begin
          repeat ($urandom_range(0, 60)) @(negedge clk);
          b = 8'($urandom);
          fq.push_back(b);
          exp_q.push_back(b);
        end
        wr_done = 1'b1;
      end
      begin
        while (!wr_done) begin
          @(negedge clk);
          if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;
        end
        tx_en = 1'b1;
      end
      begin
        int unsigned lim;
        logic [7:0]  v;
        logic        st_bit, sp_bit;
        logic [7:0]  e;
        lim = cyc + 30000;
        while (decoded < N_RAND && cyc < lim) begin
          @(negedge clk);
          if (txd == 1'b0) begin
            @(negedge clk);
            st_bit = txd;
            for (int k = 0; k < 8; k++) begin
              repeat (CPB) @(negedge clk);
              v[k] = txd;
            end
            repeat (CPB) @(negedge clk);
            sp_bit = txd;
            if (exp_q.size() == 0) begin
              chk("sb_unexpected_frame", 64'(1), 64'(0));
            end else begin
              e = exp_q.pop_front();
              chk("sb_byte", 64'({st_bit, sp_bit, v}), 64'({1'b0, 1'b1, e}));
            end
            decoded++;
          end
        end
      end
    join
    chk("sb_decoded", 64'(decoded), 64'(N_RAND));
    chk("sb_leftover", 64'(exp_q.size()), 64'(0));
    chk("sb_pops", 64'(pops - base), 64'(N_RAND));
    chk("rd_en_when_empty", 64'(viol), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Byte-serial UART transmitter that drains the shared 8-bit host-output FIFO: it pops one byte whenever the FIFO is non-empty and `tx_en` is high, then shifts it out as an 8N1 frame on `txd`. It is the read side of the core's output path: the core writes bytes into the FIFO, and this block empties it onto the serial line.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
- `clk`  in  1  system clock; all state is updated on its rising edge.
- `rst_n`  in  1  reset, **asynchronous, active-low**.
- `tx_en`  in  1  permits starting a new frame; a frame in progress always completes.
- `fifo_d`  in  8  FIFO read data (registered in the FIFO).
- `fifo_empty`  in  1  FIFO empty flag (registered in the FIFO).
- `fifo_rd_en`  out  1  one-cycle pop strobe to the FIFO.
- `txd`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in progress (START..STOP).

## Operation
- States: IDLE, START, DATA, STOP.
- **IDLE**
  - If `tx_en && !fifo_empty`, then in the same cycle:
    - `fifo_rd_en` = 1 (combinational from state and inputs);
    - `fifo_d` latched into the 8-bit shift register;
    - bit counter cleared; next state is START.
  - Otherwise `fifo_rd_en` = 0 and the block stays in IDLE.
- **START**: `txd` = 0 for `CLKS_PER_BIT` cycles, then DATA.
- **DATA**
  - `txd` = shift_reg[0] for `CLKS_PER_BIT` cycles per bit; shift right after each bit (LSB first).
  - After bit 7 (bit counter 3 bits, 0..7), go to STOP.
- **STOP**: `txd` = 1 for `CLKS_PER_BIT` cycles, then IDLE.
- `fifo_rd_en` is asserted only in IDLE. This guarantees the FIFO one-cycle read latency is respected: after a pop, `fifo_d` and `fifo_empty` are not sampled again for at least 10·`CLKS_PER_BIT` cycles.
- Baud counter:
  - width $clog2(`CLKS_PER_BIT`);
  - counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary;
  - held at 0 in IDLE.
- `tx_en` falling mid-frame has no effect on that frame. It only blocks the next pop.
- Starting a frame with `fifo_empty` = 1 is impossible. Empty-FIFO pops are never issued.

## Timing
- Reset values: state IDLE, `txd` = 1, `busy` = 0, `fifo_rd_en` = 0, shift register 0, counters 0.
- Reset asserted mid-frame:
  - `txd` returns to 1 asynchronously;
  - the popped byte is discarded and not re-read.
- `txd` and `busy` are registered outputs.
- Edge numbering: pop cycle = edge N.
  - At edge N+1: `txd` falls and `busy` rises.
  - At edge N+1 + 10·`CLKS_PER_BIT`: the stop bit ends and `busy` falls.
- Back-to-back frames: the block spends exactly one IDLE cycle between STOP and the next START. Frame period is therefore 10·`CLKS_PER_BIT` + 1 cycles.
- Bit k of a frame (start = 0, data = 1..8, stop = 9) occupies cycles N+1+k·`CLKS_PER_BIT` .. N+(k+1)·`CLKS_PER_BIT`.

## Structure
- Shared package `uart_pkg`:
  - `uart_state_t` enum (IDLE, START, DATA, STOP);
  - `UART_DATA_BITS` = 8;
  - `UART_FRAME_BITS` = 10.
- Sub-module `uart_baud_cnt`:
  - parameter `CLKS_PER_BIT`, inputs `clk`, `rst_n`, `run`, output `tick`;
  - `tick` pulses on the last cycle of each bit;
  - the counter resets to 0 when `run` is low.
- The planned UART receiver reuses `uart_pkg` and `uart_baud_cnt`.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4.
- Reset: drive `rst_n` = 0 with `fifo_empty` = 0 -> `txd` = 1, `busy` = 0, no `fifo_rd_en`. Then release reset with the FIFO empty -> still idle.
- Single byte 0xA5, `tx_en` = 1:
  - exactly one `fifo_rd_en` pulse;
  - `txd` sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1;
  - `busy` is high for 40 cycles.
- Back-to-back bytes 0x00 and 0xFF:
  - two pops 41 cycles apart;
  - second frame reads 0,1×8,1;
  - no byte is duplicated or skipped.
- Byte queued with `tx_en` = 0:
  - no pop while `tx_en` is low;
  - when `tx_en` rises, a pop occurs in the same cycle.
  - Separately, drop `tx_en` mid-frame -> the frame completes and no further pop follows.
- Reset mid-DATA after 0x3C is popped:
  - `txd` returns to 1 immediately;
  - after release, the next FIFO byte is sent and 0x3C is never retransmitted.
- Scoreboard run with the real FIFO, 200 random bytes:
  - a decoded `txd` model matches the write order exactly;
  - no `fifo_rd_en` is ever seen while `fifo_empty` = 1.
